queue_calc_sequencer: RTL and testbench

//  Initiator side of the calculator queue protocol. Accepts a token stream
//  (operands and operators), drives the queue's opcode/back inputs, reads the
//  two front entries, evaluates them in an 8-bit ALU and writes results back.

---
 rtl/queue_calc_sequencer_pkg.sv | 33 +++
 rtl/queue_calc_sequencer_if.sv | 29 ++
 rtl/queue_calc_sequencer_alu.sv | 27 ++
 rtl/queue_calc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_queue_calc_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/queue_calc_sequencer_pkg.sv
// Shared types for the calculator-queue sequencer: queue opcodes, operator
// codes, FSM states and a small operator classification helper.
package queue_calc_sequencer_pkg;

  typedef enum logic [1:0] {
    Q_PUSH    = 2'b00,
    Q_NOP     = 2'b01,
    Q_COMBINE = 2'b10,
    Q_POP     = 2'b11
  } q_op_e;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_MUL    = 3'd2,
    OP_AND    = 3'd3,
    OP_OR     = 3'd4,
    OP_XOR    = 3'd5,
    OP_RESULT = 3'd6,
    OP_CLEAR  = 3'd7
  } calc_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  function automatic logic is_alu_op(input calc_op_e op);
    return (op != OP_RESULT) && (op != OP_CLEAR);
  endfunction

endpackage

// File: rtl/queue_calc_sequencer_if.sv
// Token stream, queue control/status and result handshake of one sequencer.
// The master modport is the sequencer side, slave is its environment.
interface queue_calc_sequencer_if #(parameter int DATA_W = 8);

  logic                  in_valid;
  logic                  in_is_op;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic [1:0]            q_opcode;
  logic [DATA_W-1:0]     q_back;
  logic [2*DATA_W-1:0]   q_top_conc;
  logic                  q_is_empty;
  logic                  q_is_err;
  logic                  res_valid;
  logic [DATA_W-1:0]     res_data;
  logic                  res_ready;
  logic                  err;

  modport master (
    input  in_valid, in_is_op, in_data, q_top_conc, q_is_empty, q_is_err, res_ready,
    output in_ready, q_opcode, q_back, res_valid, res_data, err
  );

  modport slave (
    output in_valid, in_is_op, in_data, q_top_conc, q_is_empty, q_is_err, res_ready,
    input  in_ready, q_opcode, q_back, res_valid, res_data, err
  );

endinterface

// File: rtl/queue_calc_sequencer_alu.sv
// Combinational 8-bit calculator ALU; a is the queue front, b the entry behind it.
module queue_calc_sequencer_alu
  import queue_calc_sequencer_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  calc_op_e          op,
  output logic [DATA_W-1:0] y
);

  // Operator decode; RESULT and CLEAR never produce a queue value
  always_comb begin
    y = {DATA_W{1'b0}};
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = {DATA_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/queue_calc_sequencer.sv
// Initiator for the calculator queue: mirrors queue depth, issues push/combine/pop
// opcodes one token per two clocks, holds the final result and a sticky error.
module queue_calc_sequencer
  import queue_calc_sequencer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int QDEPTH = 5,
  parameter int CNT_W  = 3
) (
  input logic                    clk,
  input logic                    rst,
  queue_calc_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);

  seq_state_e          state_r, state_s;
  logic [CNT_W-1:0]    depth_r, depth_s;
  q_op_e               q_opcode_r, q_opcode_s;
  logic [DATA_W-1:0]   q_back_r, q_back_s;
  logic                res_valid_r, res_valid_s;
  logic [DATA_W-1:0]   res_data_r, res_data_s;
  logic                err_r, err_s;

  logic                in_ready_s;
  logic                accept_s;
  calc_op_e            op_s;
  logic [DATA_W-1:0]   a_s, b_s, alu_y_s;

  assign a_s        = bus.q_top_conc[DATA_W-1:0];
  assign b_s        = bus.q_top_conc[2*DATA_W-1:DATA_W];
  assign op_s       = calc_op_e'(bus.in_data[2:0]);
  assign in_ready_s = (state_r == ST_IDLE) && !res_valid_r;
  assign accept_s   = bus.in_valid && in_ready_s;

  queue_calc_sequencer_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (a_s),
    .b  (b_s),
    .op (op_s),
    .y  (alu_y_s)
  );

  // Next-state, queue command, result and error logic
  always_comb begin
    state_s     = state_r;
    depth_s     = depth_r;
    q_opcode_s  = q_opcode_r;
    q_back_s    = q_back_r;
    res_valid_s = res_valid_r;
    res_data_s  = res_data_r;
    err_s       = err_r;

    if (res_valid_r && bus.res_ready) begin
      res_valid_s = 1'b0;
    end else begin
      res_valid_s = res_valid_r;
    end

    // Queue outputs are only settled in IDLE, so the mirror is compared there
    if (bus.q_is_err) begin
      err_s = 1'b1;
    end else if ((state_r == ST_IDLE) && ((depth_r == ZERO) != bus.q_is_empty)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_s = ST_IDLE;
        end else if (!bus.in_is_op) begin
          if (depth_r < QDEPTH_C) begin
            q_opcode_s = Q_PUSH;
            q_back_s   = bus.in_data;
            depth_s    = depth_r + ONE;
            state_s    = ST_ISSUE;
          end else begin
            err_s = 1'b1;
          end
        end else if (is_alu_op(op_s)) begin
          if (depth_r >= TWO) begin
            q_opcode_s = Q_COMBINE;
            q_back_s   = alu_y_s;
            depth_s    = depth_r - ONE;
            state_s    = ST_ISSUE;
          end else begin
            err_s = 1'b1;
          end
        end else if (op_s == OP_RESULT) begin
          if (depth_r == ONE) begin
            res_data_s  = a_s;
            res_valid_s = 1'b1;
            q_opcode_s  = Q_POP;
            depth_s     = ZERO;
            state_s     = ST_ISSUE;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          if (depth_r != ZERO) begin
            q_opcode_s = Q_POP;
            depth_s    = depth_r - ONE;
            state_s    = ST_DRAIN;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end
      ST_ISSUE: begin
        q_opcode_s = Q_NOP;
        state_s    = ST_IDLE;
      end
      ST_DRAIN: begin
        if (depth_r != ZERO) begin
          q_opcode_s = Q_POP;
          depth_s    = depth_r - ONE;
        end else begin
          q_opcode_s = Q_NOP;
          state_s    = ST_IDLE;
        end
      end
      default: begin
        q_opcode_s = Q_NOP;
        state_s    = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      depth_r     <= ZERO;
      q_opcode_r  <= Q_NOP;
      q_back_r    <= {DATA_W{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      depth_r     <= depth_s;
      q_opcode_r  <= q_opcode_s;
      q_back_r    <= q_back_s;
      res_valid_r <= res_valid_s;
      res_data_r  <= res_data_s;
      err_r       <= err_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.q_opcode  = q_opcode_r;
  assign bus.q_back    = q_back_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_data  = res_data_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_queue_calc_sequencer.sv
// Bench for queue_calc_sequencer: a 5-entry queue stand-in, a vector table,
// hand-written corner sequences and random tokens against a calculator model.
module tb_queue_calc_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  queue_calc_sequencer_if #(.DATA_W(8)) bus ();

  queue_calc_sequencer #(.DATA_W(8), .QDEPTH(5), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 5-entry queue: push to back, combine replaces the front two by q_back at the back
  logic [7:0] qmem [0:4];
  logic [2:0] qcnt;
  logic       qerr;
  int         pop_count;
  logic [7:0] last_comb;

  assign bus.q_top_conc = {(qcnt > 3'd1) ? qmem[1] : 8'hFF, (qcnt > 3'd0) ? qmem[0] : 8'hFF};
  assign bus.q_is_empty = (qcnt == 3'd0);
  assign bus.q_is_err   = qerr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qcnt      <= 3'd0;
      qerr      <= 1'b0;
      pop_count <= 0;
      last_comb <= 8'h00;
      for (int i = 0; i < 5; i++) qmem[i] <= 8'h00;
    end else begin
      qerr <= 1'b0;
      case (bus.q_opcode)
        2'b00: if (qcnt < 3'd5) begin
          qmem[qcnt] <= bus.q_back;
          qcnt <= qcnt + 3'd1;
        end else qerr <= 1'b1;
        2'b10: if (qcnt >= 3'd2) begin
          for (int i = 0; i < 3; i++) qmem[i] <= qmem[i+2];
          qmem[qcnt - 3'd2] <= bus.q_back;
          qcnt <= qcnt - 3'd1;
          last_comb <= bus.q_back;
        end else qerr <= 1'b1;
        2'b11: if (qcnt != 3'd0) begin
          for (int i = 0; i < 4; i++) qmem[i] <= qmem[i+1];
          qcnt <= qcnt - 3'd1;
          pop_count <= pop_count + 1;
        end else qerr <= 1'b1;
        default: ;
      endcase
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one token, then wait until the sequencer is back in IDLE with the queue settled
  task automatic send(input logic is_op, input logic [7:0] data, output int busy);
    bit ok;
    busy = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL in_ready_wait: in_ready stayed 0 for 50 cycles, required 1");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_is_op = is_op;
    bus.in_data  = data;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((bus.in_ready || bus.res_valid) && bus.q_opcode == 2'b01) begin ok = 1; break; end
      busy++;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL settle_wait: not idle after 50 cycles, q_opcode=%0b", bus.q_opcode);
    end
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  typedef struct {
    bit         is_op;
    logic [7:0] data;
    bit         err;
    bit         rv;
    logic [7:0] rd;
    int         depth;
    bit         chk_back;
    logic [7:0] back;
  } vec_t;

  function automatic vec_t mk(input bit is_op, input logic [7:0] data, input bit e, input bit rv,
                              input logic [7:0] rd, input int depth, input bit cb, input logic [7:0] back);
    vec_t v;
    v.is_op = is_op; v.data = data; v.err = e; v.rv = rv;
    v.rd = rd; v.depth = depth; v.chk_back = cb; v.back = back;
    return v;
  endfunction

  vec_t tbl[$];
  logic [7:0] ms[$];
  bit         m_err;
  bit         m_rv;
  logic [7:0] m_rd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int busy;
    int p0;
    bus.in_valid = 1'b0; bus.in_is_op = 1'b0; bus.in_data = 8'h00; bus.res_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst q_opcode", bus.q_opcode, 2'b01);
    check("rst q_back", bus.q_back, 8'h00);
    check("rst res_valid", bus.res_valid, 1'b0);
    check("rst res_data", bus.res_data, 8'h00);
    check("rst err", bus.err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst in_ready", bus.in_ready, 1'b1);

    // Vector table: is_op, data, err, res_valid, res_data, queue depth, check back, back
    tbl.push_back(mk(0, 8'd3,  0, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'd4,  0, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'hA8, 0, 0, 8'h00, 1, 1, 8'h07));
    tbl.push_back(mk(1, 8'd6,  0, 1, 8'h07, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'd10, 0, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'd3,  0, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd1,  0, 0, 8'h00, 1, 1, 8'h07));
    tbl.push_back(mk(1, 8'd6,  0, 1, 8'h07, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'd3,  0, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'd10, 0, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd1,  0, 0, 8'h00, 1, 1, 8'hF9));
    tbl.push_back(mk(1, 8'd6,  0, 1, 8'hF9, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'd16, 0, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'd16, 0, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd2,  0, 0, 8'h00, 1, 1, 8'h00));
    tbl.push_back(mk(1, 8'd6,  0, 1, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h0F, 0, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h3C, 0, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd3,  0, 0, 8'h00, 1, 1, 8'h0C));
    tbl.push_back(mk(0, 8'h30, 0, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd4,  0, 0, 8'h00, 1, 1, 8'h3C));
    tbl.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd5,  0, 0, 8'h00, 1, 1, 8'hC3));
    tbl.push_back(mk(1, 8'd6,  0, 1, 8'hC3, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'd7,  0, 0, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'd5,  0, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'd0,  1, 0, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'd6,  1, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd6,  1, 0, 8'h00, 2, 0, 8'h00));
    tbl.push_back(mk(1, 8'd1,  1, 0, 8'h00, 1, 1, 8'hFF));
    tbl.push_back(mk(1, 8'd6,  1, 1, 8'hFF, 0, 0, 8'h00));

    for (int k = 0; k < tbl.size(); k++) begin
      send(tbl[k].is_op, tbl[k].data, busy);
      check($sformatf("vec%0d err", k), bus.err, tbl[k].err);
      check($sformatf("vec%0d res_valid", k), bus.res_valid, tbl[k].rv);
      if (tbl[k].rv) check($sformatf("vec%0d res_data", k), bus.res_data, tbl[k].rd);
      check($sformatf("vec%0d depth", k), qcnt, tbl[k].depth);
      if (tbl[k].chk_back) check($sformatf("vec%0d combine back", k), last_comb, tbl[k].back);
      if (bus.res_valid) take_result();
    end

    // Result is held until consumed and blocks new tokens
    do_reset();
    send(0, 8'd3, busy); send(0, 8'd4, busy); send(1, 8'd0, busy); send(1, 8'd6, busy);
    bus.in_valid = 1'b1; bus.in_is_op = 1'b0; bus.in_data = 8'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold res_valid", bus.res_valid, 1'b1);
      check("hold in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    check("hold blocked push", qcnt, 3'd0);
    check("hold res_data", bus.res_data, 8'd7);
    take_result();
    check("consumed res_valid", bus.res_valid, 1'b0);
    check("consumed err", bus.err, 1'b0);
    check("consumed empty", bus.q_is_empty, 1'b1);

    // Overflow, then CLEAR drains all five entries on consecutive clocks
    do_reset();
    for (int i = 1; i <= 6; i++) send(0, 8'(i), busy);
    check("overflow err", bus.err, 1'b1);
    check("overflow depth", qcnt, 3'd5);
    check("overflow front", bus.q_top_conc[7:0], 8'd1);
    p0 = pop_count;
    send(1, 8'd7, busy);
    check("clear pops", pop_count - p0, 5);
    check("clear busy>=5", busy >= 5, 1'b1);
    check("clear empty", bus.q_is_empty, 1'b1);
    check("clear in_ready", bus.in_ready, 1'b1);

    // RESULT with two entries is rejected
    do_reset();
    send(0, 8'd1, busy); send(0, 8'd2, busy); send(1, 8'd6, busy);
    check("result d2 err", bus.err, 1'b1);
    check("result d2 res_valid", bus.res_valid, 1'b0);
    check("result d2 depth", qcnt, 3'd2);

    // Reset during DRAIN abandons everything at once
    do_reset();
    for (int i = 1; i <= 6; i++) send(0, 8'(i * 3), busy);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_is_op = 1'b1; bus.in_data = 8'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("drain q_opcode", bus.q_opcode, 2'b11);
    check("drain err before rst", bus.err, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid-drain rst q_opcode", bus.q_opcode, 2'b01);
    check("mid-drain rst err", bus.err, 1'b0);
    check("mid-drain rst empty", bus.q_is_empty, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    send(0, 8'd9, busy);
    send(1, 8'd6, busy);
    check("post-rst err", bus.err, 1'b0);
    check("post-rst res_valid", bus.res_valid, 1'b1);
    check("post-rst res_data", bus.res_data, 8'd9);
    if (bus.res_valid) take_result();

    // Random tokens against the calculator model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      ms.delete(); m_err = 0; m_rv = 0; m_rd = 8'h00;
      for (int t = 0; t < 60; t++) begin
        logic       is_op;
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] a, b;
        is_op = ($urandom_range(0, 99) < 45);
        op    = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        data  = is_op ? {5'($urandom), op} : 8'($urandom);
        m_rv  = 0;
        if (!is_op) begin
          if (ms.size() < 5) ms.push_back(data); else m_err = 1;
        end else if (op <= 3'd5) begin
          if (ms.size() >= 2) begin
            a = ms.pop_front(); b = ms.pop_front();
            ms.push_back(ref_alu(op, a, b));
          end else m_err = 1;
        end else if (op == 3'd6) begin
          if (ms.size() == 1) begin m_rd = ms.pop_front(); m_rv = 1; end else m_err = 1;
        end else ms.delete();
        send(is_op, data, busy);
        check($sformatf("rnd%0d.%0d err", r, t), bus.err, m_err);
        check($sformatf("rnd%0d.%0d res_valid", r, t), bus.res_valid, m_rv);
        if (m_rv) check($sformatf("rnd%0d.%0d res_data", r, t), bus.res_data, m_rd);
        check($sformatf("rnd%0d.%0d depth", r, t), qcnt, ms.size());
        if (ms.size() > 0) check($sformatf("rnd%0d.%0d front", r, t), bus.q_top_conc[7:0], ms[0]);
        if (bus.res_valid) take_result();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
